// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX launch sequencer and the future RX-side buffer.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with registered count/full/empty.
// A pop never frees space for a push in the same cycle.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [UART_BYTE_W-1:0] din,
  output logic [UART_BYTE_W-1:0] dout,
  output logic [ADDR_W:0]        count,
  output logic                   full,
  output logic                   empty
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [UART_BYTE_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]        count_q, count_d;
  logic                   full_q, full_d;
  logic                   empty_q, empty_d;
  logic                   push_ok, pop_ok;

  always_comb begin
    push_ok  = push & ~full_q;
    pop_ok   = pop & ~empty_q;
    wr_ptr_d = wr_ptr_q + ADDR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + ADDR_W'(pop_ok);
    count_d  = count_q + (ADDR_W + 1)'(push_ok) - (ADDR_W + 1)'(pop_ok);
    full_d   = (count_d == FULL_CNT);
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer plus launch sequencer feeding async_transmitter's
// TxD_start/TxD_data/TxD_busy handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned BUSY_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_BYTE_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  output logic                   tx_err,
  output logic                   TxD_start,
  output logic [UART_BYTE_W-1:0] TxD_data,
  input  logic                   TxD_busy
);

  localparam int unsigned   WAIT_W    = $clog2(BUSY_WAIT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT - 1);

  tx_state_t              state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d, wait_inc;
  logic                   start_q, start_d;
  logic [UART_BYTE_W-1:0] data_q, data_d;
  logic                   ovf_q, ovf_d;
  logic                   err_q, err_d;
  logic                   pop;
  logic [UART_BYTE_W-1:0] fifo_dout;
  logic                   fifo_full, fifo_empty;

  uart_byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    wait_inc = wait_q + 1'b1;
    start_d  = 1'b0;
    data_d   = data_q;
    err_d    = err_q;
    pop      = 1'b0;
    ovf_d    = ovf_q | (wr_en & fifo_full);
    unique case (state_q)
      // Waiting for busy low here also protects a frame still running across a reset.
      IDLE: begin
        if (!fifo_empty && !TxD_busy) begin
          pop     = 1'b1;
          data_d  = fifo_dout;
          start_d = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        wait_d  = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (TxD_busy) begin
          state_d = WAIT_DONE;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WAIT_LAST) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!TxD_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      start_q <= start_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign full      = fifo_full;
  assign empty     = fifo_empty;
  assign overflow  = ovf_q;
  assign tx_err    = err_q;
  assign TxD_start = start_q;
  assign TxD_data  = data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a queue-based reference model
// and a behavioural async_transmitter.
module tb_uart_tx_fifo;

  localparam int DEPTH     = 16;
  localparam int ADDR_W    = 4;
  localparam int BUSY_WAIT = 4;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full, empty, overflow, tx_err, TxD_start, TxD_busy;
  logic [ADDR_W:0]   count;
  logic [7:0]        TxD_data;

  uart_tx_fifo #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .BUSY_WAIT (BUSY_WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .tx_err    (tx_err),
    .TxD_start (TxD_start),
    .TxD_data  (TxD_data),
    .TxD_busy  (TxD_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Transmitter model state
  int busy_len = 20;
  int busy_cnt = 0;
  bit mute     = 0;
  bit hold     = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         m_free = 1;
  bit         m_seen = 0;
  int         m_age  = 0;
  bit         m_ovf  = 0;
  bit         m_err  = 0;
  bit         m_start = 0;
  logic [7:0] m_data = 8'h00;

  int         dut_starts = 0;
  logic [7:0] last_tx    = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the reference: bytes leave in write order, a launch
  // needs an idle link and busy low, and a launch that never sees busy
  // is abandoned BUSY_WAIT edges after the start pulse appears.
  task automatic model_edge(input bit we, input logic [7:0] wd, input bit r, input bit busy);
    bit was_full;
    if (r) begin
      q.delete();
      m_free = 1; m_seen = 0; m_ovf = 0; m_err = 0; m_start = 0; m_data = 8'h00;
      return;
    end
    was_full = (q.size() == DEPTH);
    m_start  = 0;
    if (m_free) begin
      if (q.size() > 0 && !busy) begin
        m_data  = q.pop_front();
        m_start = 1;
        m_free  = 0;
        m_age   = 0;
        m_seen  = 0;
      end
    end else begin
      m_age++;
      if (m_seen) begin
        if (!busy) m_free = 1;
      end else if (m_age >= 2) begin
        if (busy) m_seen = 1;
        else if (m_age >= BUSY_WAIT) begin
          m_err  = 1;
          m_free = 1;
        end
      end
    end
    if (we) begin
      if (was_full) m_ovf = 1;
      else q.push_back(wd);
    end
  endtask

  task automatic step(input bit we, input logic [7:0] wd, input bit r);
    bit start_seen;
    wr_en   = we;
    wr_data = wd;
    rst     = r;
    model_edge(we, wd, r, TxD_busy);
    start_seen = TxD_start;
    @(posedge clk);
    #1;
    if (start_seen && !mute) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    TxD_busy = (busy_cnt > 0) || hold;
    if (TxD_start) begin
      dut_starts++;
      last_tx = TxD_data;
    end
    check_eq("start",    32'(TxD_start), 32'(m_start));
    check_eq("data",     32'(TxD_data),  32'(m_data));
    check_eq("count",    32'(count),     32'(q.size()));
    check_eq("full",     32'(full),      32'(q.size() == DEPTH));
    check_eq("empty",    32'(empty),     32'(q.size() == 0));
    check_eq("overflow", 32'(overflow),  32'(m_ovf));
    check_eq("tx_err",   32'(tx_err),    32'(m_err));
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 3000; i++) begin
      if (q.size() == 0 && m_free && !TxD_busy) begin
        done = 1;
        break;
      end
      step(0, 8'h00, 0);
    end
    check_eq("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; TxD_busy = 1'b0;
    @(negedge clk);
    repeat (3) step(0, 8'h00, 1);

    // Single byte into an idle block: launch exactly one edge after the write
    step(1, 8'h44, 0);
    check_eq("t1_no_start_yet", 32'(TxD_start), 32'd0);
    step(0, 8'h00, 0);
    check_eq("t1_start", 32'(TxD_start), 32'd1);
    check_eq("t1_data",  32'(TxD_data),  32'h44);
    check_eq("t1_count", 32'(count),     32'd0);
    drain();

    // Burst of 16 with a 20-cycle transmitter
    s0 = dut_starts;
    for (int i = 1; i <= 16; i++) step(1, 8'(i), 0);
    drain();
    check_eq("t2_launches", 32'(dut_starts - s0), 32'd16);
    check_eq("t2_last",     32'(last_tx),         32'h10);

    // Fill while the transmitter is held busy, then overflow
    busy_len = 60;
    step(1, 8'hF0, 0);
    repeat (3) step(0, 8'h00, 0);
    for (int i = 0; i < 16; i++) step(1, 8'($urandom_range(0, 255)), 0);
    step(1, 8'hAA, 0);
    check_eq("t3_overflow", 32'(overflow), 32'd1);
    check_eq("t3_count",    32'(count),    32'd16);
    busy_len = 20;
    drain();
    check_eq("t3_ovf_sticky", 32'(overflow), 32'd1);

    // Transmitter never answers: tx_err, then recovery
    step(0, 8'h00, 1);
    mute = 1;
    step(1, 8'h55, 0);
    repeat (8) step(0, 8'h00, 0);
    check_eq("t4_tx_err", 32'(tx_err), 32'd1);
    mute = 0;
    s0 = dut_starts;
    step(1, 8'h66, 0);
    drain();
    check_eq("t4_recover", 32'(dut_starts - s0), 32'd1);
    check_eq("t4_data",    32'(last_tx),         32'h66);

    // Write and launch on the same edge with three bytes queued
    hold = 1; TxD_busy = 1'b1;
    step(1, 8'h31, 0);
    step(1, 8'h32, 0);
    step(1, 8'h33, 0);
    check_eq("t5_pre", 32'(count), 32'd3);
    hold = 0; TxD_busy = (busy_cnt > 0);
    step(1, 8'h34, 0);
    check_eq("t5_count", 32'(count),     32'd3);
    check_eq("t5_start", 32'(TxD_start), 32'd1);
    drain();

    // Reset during WAIT_DONE with bytes queued
    for (int i = 0; i < 6; i++) step(1, 8'($urandom_range(0, 255)), 0);
    repeat (4) step(0, 8'h00, 0);
    check_eq("t6_queued", 32'(count), 32'd5);
    step(0, 8'h00, 1);
    check_eq("t6_count_rst", 32'(count), 32'd0);
    s0 = dut_starts;
    drain();
    check_eq("t6_no_start", 32'(dut_starts - s0), 32'd0);
    step(1, 8'h77, 0);
    drain();
    check_eq("t6_new", 32'(last_tx), 32'h77);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 3) busy_len = $urandom_range(1, 30);
      if ($urandom_range(0, 199) == 0) mute = ~mute;
      step(($urandom_range(0, 99) < 40), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 299) == 0));
    end
    mute = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
